// File: rtl/spi_sram_slave_if.sv
// SPI bus bundle between a master (CPU / testbench) and the serial SRAM slave.
interface spi_sram_slave_if;
  logic spi_cs_n;
  logic spi_sclk;
  logic spi_mosi;
  logic spi_miso;

  modport master (output spi_cs_n, output spi_sclk, output spi_mosi, input spi_miso);
  modport slave  (input spi_cs_n, input spi_sclk, input spi_mosi, output spi_miso);
endinterface

// File: rtl/spi_sram_slave.sv
// Clock-oversampled SPI serial SRAM slave (23LC512-style, sequential mode).
// Supports READ, WRITE, RDSR and WRSR; any other opcode is ignored until CS rises.
module spi_sram_slave #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter logic [7:0]  MODE_RESET = 8'h40
) (
  input logic             clk,
  input logic             rst_n,
  spi_sram_slave_if.slave spi
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned CNT_W = $clog2(ADDR_WIDTH);

  localparam logic [7:0] OP_WRSR  = 8'h01;
  localparam logic [7:0] OP_WRITE = 8'h02;
  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_RDSR  = 8'h05;

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_READ, S_WRITE, S_RDSR, S_WRSR, S_IGNORE
  } state_e;

  logic [7:0] memory [DEPTH];

  logic cs_meta_q, cs_sync_q, cs_prev_q;
  logic sclk_meta_q, sclk_sync_q, sclk_prev_q;
  logic mosi_meta_q, mosi_sync_q;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]             shift_q, shift_d;
  logic [7:0]             tx_q, tx_d;
  logic [7:0]             cmd_q, cmd_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [7:0]             mode_q, mode_d;
  logic                   miso_q, miso_d;
  logic                   wr_en_q, wr_en_d;
  logic [7:0]             wr_data_q, wr_data_d;
  logic [7:0]             rd_data_q;

  logic       sclk_rise_c, sclk_fall_c, cs_fall_c;
  logic [7:0] rx_byte_c;

  // CS synchronizer resets to "selected" so a CS already low at reset release is not seen as a new fall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_meta_q   <= 1'b0;
      cs_sync_q   <= 1'b0;
      cs_prev_q   <= 1'b0;
      sclk_meta_q <= 1'b0;
      sclk_sync_q <= 1'b0;
      sclk_prev_q <= 1'b0;
      mosi_meta_q <= 1'b0;
      mosi_sync_q <= 1'b0;
    end else begin
      cs_meta_q   <= spi.spi_cs_n;
      cs_sync_q   <= cs_meta_q;
      cs_prev_q   <= cs_sync_q;
      sclk_meta_q <= spi.spi_sclk;
      sclk_sync_q <= sclk_meta_q;
      sclk_prev_q <= sclk_sync_q;
      mosi_meta_q <= spi.spi_mosi;
      mosi_sync_q <= mosi_meta_q;
    end
  end

  assign sclk_rise_c = sclk_sync_q & ~sclk_prev_q;
  assign sclk_fall_c = ~sclk_sync_q & sclk_prev_q;
  assign cs_fall_c   = cs_prev_q & ~cs_sync_q;
  assign rx_byte_c   = {shift_q[6:0], mosi_sync_q};

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    cmd_d     = cmd_q;
    addr_d    = addr_q;
    mode_d    = mode_q;
    miso_d    = miso_q;
    wr_en_d   = 1'b0;
    wr_data_d = wr_data_q;

    // A completed write byte advances the address even if CS rises right after it
    if (wr_en_q) addr_d = addr_q + ADDR_WIDTH'(1);

    unique case (state_q)
      S_IDLE: begin
        if (cs_fall_c) begin
          state_d   = S_CMD;
          bit_cnt_d = '0;
          shift_d   = '0;
        end
      end
      S_CMD: begin
        if (sclk_rise_c) begin
          shift_d   = rx_byte_c;
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == CNT_W'(7)) begin
            bit_cnt_d = '0;
            cmd_d     = rx_byte_c;
            unique case (rx_byte_c)
              OP_READ, OP_WRITE: state_d = S_ADDR;
              OP_RDSR:           state_d = S_RDSR;
              OP_WRSR:           state_d = S_WRSR;
              default:           state_d = S_IGNORE;
            endcase
          end
        end
      end
      S_ADDR: begin
        if (sclk_rise_c) begin
          addr_d    = {addr_q[ADDR_WIDTH-2:0], mosi_sync_q};
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == CNT_W'(ADDR_WIDTH - 1)) begin
            bit_cnt_d = '0;
            state_d   = (cmd_q == OP_READ) ? S_READ : S_WRITE;
          end
        end
      end
      S_READ: begin
        // rd_data_q tracks memory[addr_q] and settles well within the SCLK low phase
        if (sclk_fall_c) begin
          if (bit_cnt_q == '0) begin
            miso_d = rd_data_q[7];
            tx_d   = {rd_data_q[6:0], 1'b0};
          end else begin
            miso_d = tx_q[7];
            tx_d   = {tx_q[6:0], 1'b0};
          end
        end
        if (sclk_rise_c) begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == CNT_W'(7)) begin
            bit_cnt_d = '0;
            addr_d    = addr_q + ADDR_WIDTH'(1);
          end
        end
      end
      S_WRITE: begin
        if (sclk_rise_c) begin
          shift_d   = rx_byte_c;
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == CNT_W'(7)) begin
            bit_cnt_d = '0;
            wr_en_d   = 1'b1;
            wr_data_d = rx_byte_c;
          end
        end
      end
      S_RDSR: begin
        if (sclk_fall_c) begin
          if (bit_cnt_q == '0) begin
            miso_d = mode_q[7];
            tx_d   = {mode_q[6:0], 1'b0};
          end else begin
            miso_d = tx_q[7];
            tx_d   = {tx_q[6:0], 1'b0};
          end
        end
        if (sclk_rise_c) begin
          bit_cnt_d = (bit_cnt_q == CNT_W'(7)) ? '0 : bit_cnt_q + CNT_W'(1);
        end
      end
      S_WRSR: begin
        if (sclk_rise_c) begin
          shift_d   = rx_byte_c;
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == CNT_W'(7)) begin
            bit_cnt_d = '0;
            mode_d    = rx_byte_c;
            state_d   = S_IGNORE;
          end
        end
      end
      S_IGNORE: ;
      default: state_d = S_IDLE;
    endcase

    if (cs_sync_q) begin
      state_d   = S_IDLE;
      bit_cnt_d = '0;
      miso_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      tx_q      <= '0;
      cmd_q     <= '0;
      addr_q    <= '0;
      mode_q    <= MODE_RESET;
      miso_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      cmd_q     <= cmd_d;
      addr_q    <= addr_d;
      mode_q    <= mode_d;
      miso_q    <= miso_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
    end
  end

  // Storage array is deliberately unreset so preloaded contents survive rst_n
  always_ff @(posedge clk) begin
    if (wr_en_q) memory[addr_q] <= wr_data_q;
    rd_data_q <= memory[addr_q];
  end

  assign spi.spi_miso = miso_q;

endmodule

// File: tb/tb_spi_sram_slave.sv
// Directed bench for spi_sram_slave: SPI master tasks drive mode-0 transfers and check MISO/memory.
module tb_spi_sram_slave;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_sram_slave_if bus ();

  spi_sram_slave #(
    .ADDR_WIDTH(16),
    .MODE_RESET(8'h40)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .spi  (bus)
  );

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Mode 0: data set while SCLK low, MISO sampled just before the rising edge
  task automatic xfer_bit(input logic b, output logic r);
    bus.spi_mosi = b;
    wait_clk(5);
    r = bus.spi_miso;
    bus.spi_sclk = 1'b1;
    wait_clk(5);
    bus.spi_sclk = 1'b0;
  endtask

  task automatic xfer_byte(input logic [7:0] tx, output logic [7:0] rx);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      xfer_bit(tx[i], b);
      rx[i] = b;
    end
  endtask

  task automatic cs_begin();
    bus.spi_cs_n = 1'b0;
    wait_clk(5);
  endtask

  task automatic cs_end();
    wait_clk(5);
    bus.spi_cs_n = 1'b1;
    bus.spi_mosi = 1'b0;
    wait_clk(8);
  endtask

  task automatic send3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    logic [7:0] rx;
    xfer_byte(a, rx);
    xfer_byte(b, rx);
    xfer_byte(c, rx);
  endtask

  logic [7:0] rx;
  logic [7:0] bits_a5;
  logic       bit_r;

  initial begin
    bus.spi_cs_n = 1'b1;
    bus.spi_sclk = 1'b0;
    bus.spi_mosi = 1'b0;
    wait_clk(4);
    rst_n = 1'b1;
    wait_clk(4);
    check_eq("reset_miso", 32'(bus.spi_miso), 32'h0);

    // Status register: reset value, repeats, then WRSR update
    cs_begin();
    xfer_byte(8'h05, rx);
    xfer_byte(8'h00, rx);
    check_eq("rdsr_reset", 32'(rx), 32'h40);
    xfer_byte(8'h00, rx);
    check_eq("rdsr_repeat", 32'(rx), 32'h40);
    cs_end();
    cs_begin();
    xfer_byte(8'h01, rx);
    xfer_byte(8'h00, rx);
    cs_end();
    cs_begin();
    xfer_byte(8'h05, rx);
    xfer_byte(8'h00, rx);
    check_eq("rdsr_after_wrsr", 32'(rx), 32'h00);
    cs_end();

    // Single-byte read, bit by bit
    dut.memory[16'h0010] = 8'hA5;
    cs_begin();
    send3(8'h03, 8'h00, 8'h10);
    for (int i = 7; i >= 0; i--) begin
      xfer_bit(1'b0, bit_r);
      bits_a5[i] = bit_r;
    end
    check_eq("read_a5", 32'(bits_a5), 32'hA5);
    cs_end();
    check_eq("miso_idle_after_read", 32'(bus.spi_miso), 32'h0);

    // Sequential write then read-back
    cs_begin();
    send3(8'h02, 8'h12, 8'h34);
    send3(8'hDE, 8'hAD, 8'hBE);
    cs_end();
    check_eq("wr_mem_1234", 32'(dut.memory[16'h1234]), 32'hDE);
    check_eq("wr_mem_1235", 32'(dut.memory[16'h1235]), 32'hAD);
    check_eq("wr_mem_1236", 32'(dut.memory[16'h1236]), 32'hBE);
    cs_begin();
    send3(8'h03, 8'h12, 8'h34);
    xfer_byte(8'h00, rx);
    check_eq("rd_1234", 32'(rx), 32'hDE);
    xfer_byte(8'h00, rx);
    check_eq("rd_1235", 32'(rx), 32'hAD);
    xfer_byte(8'h00, rx);
    check_eq("rd_1236", 32'(rx), 32'hBE);
    cs_end();

    // Address wrap from top of array to zero
    dut.memory[16'hFFFF] = 8'h11;
    dut.memory[16'h0000] = 8'h22;
    cs_begin();
    send3(8'h03, 8'hFF, 8'hFF);
    xfer_byte(8'h00, rx);
    check_eq("wrap_ffff", 32'(rx), 32'h11);
    xfer_byte(8'h00, rx);
    check_eq("wrap_0000", 32'(rx), 32'h22);
    cs_end();

    // Partial trailing byte must be discarded
    dut.memory[16'h0021] = 8'h5A;
    cs_begin();
    send3(8'h02, 8'h00, 8'h20);
    xfer_byte(8'hC3, rx);
    for (int i = 0; i < 4; i++) xfer_bit(1'b1, bit_r);
    cs_end();
    check_eq("partial_full_byte", 32'(dut.memory[16'h0020]), 32'hC3);
    check_eq("partial_discarded", 32'(dut.memory[16'h0021]), 32'h5A);

    // Reset in the middle of a write; stored byte must survive
    dut.memory[16'h0030] = 8'h77;
    cs_begin();
    send3(8'h02, 8'h00, 8'h30);
    for (int i = 0; i < 4; i++) xfer_bit(1'b0, bit_r);
    rst_n = 1'b0;
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(2);
    check_eq("miso_after_midreset", 32'(bus.spi_miso), 32'h0);
    cs_end();
    check_eq("miso_cs_high", 32'(bus.spi_miso), 32'h0);
    check_eq("mem_30_kept", 32'(dut.memory[16'h0030]), 32'h77);
    cs_begin();
    send3(8'h03, 8'h00, 8'h30);
    xfer_byte(8'h00, rx);
    check_eq("rd_after_reset", 32'(rx), 32'h77);
    cs_end();
    check_eq("miso_final_idle", 32'(bus.spi_miso), 32'h0);

    // Mode register is back to its reset value after the mid-transaction reset
    cs_begin();
    xfer_byte(8'h05, rx);
    xfer_byte(8'h00, rx);
    check_eq("rdsr_post_reset", 32'(rx), 32'h40);
    cs_end();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_sram_slave.md
Name: spi_sram_slave

Overview:
Synthesizable, clock-oversampled SPI serial SRAM slave, functionally equivalent to a 23LC512-class part in sequential mode. It serves as the external program/data memory of the TinyTapeout CPU over the shared SPI bus, selected by that bus's RAM chip-select. The storage array is named `memory` so benches can preload and inspect it hierarchically.

Parameters:
ADDR_WIDTH, 16, address bits carried in each command; array depth = 2**ADDR_WIDTH bytes.
MODE_RESET, 8'h40, reset value of the mode register (sequential mode).

Ports:
clk  input  1  system clock; all logic on rising edge
rst_n  input  1  asynchronous active-low reset
spi_cs_n  input  1  chip select, active low
spi_sclk  input  1  SPI clock, mode 0 (CPOL=0, CPHA=0)
spi_mosi  input  1  serial data in, MSB first
spi_miso  output  1  serial data out, MSB first

Behaviour:
- Input sync: cs_n, sclk and mosi each pass through a 2-flop synchronizer. SCLK edges are detected from the synchronized value. The bus requires SCLK high and low phases of at least 4 clk each.
- Reset: FSM=IDLE, bit counter=0, shift regs=0, addr=0, mode=MODE_RESET, spi_miso=0. `memory` is not reset, so preloaded contents survive.
- CS high (synced): FSM forced to IDLE, counters cleared, spi_miso=0. The line is driven to 0, never Z.
- Sampling: mosi is sampled on SCLK rising edges. spi_miso changes only on SCLK falling edges.
- States: IDLE -> CMD (8 bits) -> ADDR (ADDR_WIDTH bits) -> READ | WRITE; CMD -> RDSR | WRSR; any other opcode -> IGNORE until CS rises.
- CS falling edge: enters CMD with the bit counter at 0.
- READ 0x03:
  - After the last address bit's rising edge, the next SCLK falling edge drives bit 7 of memory[addr].
  - Each following falling edge shifts out the next bit.
  - After the 8th bit's rising edge, addr increments, and the following falling edge drives bit 7 of the new byte.
- WRITE 0x02:
  - Each 8 rising edges assemble a byte; memory[addr] is written within 2 clk of the 8th edge, then addr increments.
- Address wrap: addr increments modulo 2**ADDR_WIDTH, so 0xFFFF -> 0x0000.
- RDSR 0x05: returns the mode register on the next 8 falling edges, repeating if clocking continues.
- WRSR 0x01: the next 8 bits load the mode register. The mode value does not alter behaviour; the part is always sequential.
- CS rise mid-byte in WRITE: the partial byte is discarded and earlier completed bytes persist. Mid-READ: output stops and spi_miso goes 0.
- Reset mid-transaction: immediate IDLE. Completed writes persist; the next CS fall starts a fresh command.
- Concurrent backdoor writes to `memory` are permitted only while CS is high.

Test Plan:
- Backdoor memory[0x0010]=8'hA5; CS low, send 03 00 10, clock 8 bits -> MISO bits 1,0,1,0,0,1,0,1.
- Send 02 12 34 DE AD BE, CS high -> memory[0x1234..0x1236]=DE,AD,BE. Then read 03 12 34 for 24 bits -> DEADBE.
- Backdoor memory[0xFFFF]=8'h11, memory[0x0000]=8'h22; read 03 FF FF for 16 bits -> 11 then 22 (wrap).
- Send 02 00 20 C3, then 4 bits of the next byte, CS high -> memory[0x0020]=C3 and memory[0x0021] unchanged.
- After reset: RDSR 05 -> 40. Then WRSR 01 00, RDSR -> 00.
- Send 02 00 30 then half a byte and assert rst_n=0 for 3 clk. New transaction 03 00 30 -> original byte returned; spi_miso=0 whenever CS is high.
